// File: rtl/rf_bank_req_queue_pkg.sv
// Shared constants, entry type and sizing helper for the register-file
// bank request queue.
package rf_pkg;

    localparam int NUM_BANKS = 4;
    localparam int DEPTH     = 4;
    localparam int ROW_W     = 3;
    localparam int OCID_W    = 2;
    localparam int BANK_W    = $clog2(NUM_BANKS);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = $clog2(DEPTH + 1);

    // One queued operand read: target row, destination collector, operand select
    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [OCID_W-1:0] ocid;
        logic              opsel;
    } entry_t;

    // True when a bank holding 'count' entries can absorb 'need' more
    function automatic logic slots_fit(input logic [CNT_W-1:0] count,
                                       input logic [1:0]       need);
        logic [CNT_W:0] sum;
        sum = (CNT_W + 1)'(count) + (CNT_W + 1)'(need);
        return (sum <= (CNT_W + 1)'(DEPTH));
    endfunction

endpackage

// File: rtl/rf_bank_req_queue_if.sv
// Request, writeback and per-bank issue signals of the bank request queue.
interface rf_bank_req_queue_if;
    import rf_pkg::*;

    logic                        req_valid;
    logic                        req_2op;
    logic [ROW_W-1:0]            rowid_a;
    logic [BANK_W-1:0]           bankid_a;
    logic [ROW_W-1:0]            rowid_b;
    logic [BANK_W-1:0]           bankid_b;
    logic [OCID_W-1:0]           ocid;
    logic                        req_ready;
    logic                        wb_valid;
    logic [BANK_W-1:0]           wb_bank;
    logic [NUM_BANKS-1:0]        bk_rd_vld;
    logic [NUM_BANKS*ROW_W-1:0]  bk_rd_row;
    logic [NUM_BANKS*OCID_W-1:0] bk_rd_ocid;
    logic [NUM_BANKS-1:0]        bk_rd_opsel;
    logic [NUM_BANKS-1:0]        bank_full;

    modport master (
        output req_valid, req_2op, rowid_a, bankid_a, rowid_b, bankid_b, ocid,
        output wb_valid, wb_bank,
        input  req_ready, bk_rd_vld, bk_rd_row, bk_rd_ocid, bk_rd_opsel, bank_full
    );

    modport slave (
        input  req_valid, req_2op, rowid_a, bankid_a, rowid_b, bankid_b, ocid,
        input  wb_valid, wb_bank,
        output req_ready, bk_rd_vld, bk_rd_row, bk_rd_ocid, bk_rd_opsel, bank_full
    );

endinterface

// File: rtl/rf_bank_req_queue_bank_req_fifo.sv
// Per-bank request FIFO: two write ports (a then b), one read port feeding a
// registered issue slot. A stalled bank keeps its head and issues nothing.
module bank_req_fifo
    import rf_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_a,
    input  entry_t           wr_data_a,
    input  logic             wr_en_b,
    input  entry_t           wr_data_b,
    input  logic             stall,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             rd_vld,
    output entry_t           rd_data
);

    entry_t            mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              rd_vld_r;
    entry_t            rd_data_r;

    logic              pop_s;
    logic [CNT_W-1:0]  push_cnt_s;
    logic              slot0_en_s;
    entry_t            slot0_data_s;
    logic              slot1_en_s;
    logic [PTR_W-1:0]  wr_ptr_p1_s;

    // Decide pop and map the write ports onto the next one or two slots
    always_comb begin
        pop_s        = 1'b0;
        push_cnt_s   = CNT_W'(wr_en_a) + CNT_W'(wr_en_b);
        slot0_en_s   = wr_en_a || wr_en_b;
        slot0_data_s = wr_data_b;
        slot1_en_s   = wr_en_a && wr_en_b;
        wr_ptr_p1_s  = wr_ptr_r + PTR_W'(1);
        if (wr_en_a) begin
            slot0_data_s = wr_data_a;
        end else begin
            slot0_data_s = wr_data_b;
        end
        if ((count_r != {CNT_W{1'b0}}) && !stall) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Storage array; contents are don't-care until a push makes them valid
    always_ff @(posedge clk) begin
        if (slot0_en_s) begin
            mem_r[wr_ptr_r] <= slot0_data_s;
        end
        if (slot1_en_s) begin
            mem_r[wr_ptr_p1_s] <= wr_data_b;
        end
    end

    // Pointers and occupancy; same-edge push and pop are both applied
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(push_cnt_s);
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + push_cnt_s - CNT_W'(pop_s);
        end
    end

    // Registered issue slot; payload holds its last value when nothing pops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld_r  <= 1'b0;
            rd_data_r <= '0;
        end else begin
            rd_vld_r <= pop_s;
            if (pop_s) begin
                rd_data_r <= mem_r[rd_ptr_r];
            end
        end
    end

    assign count   = count_r;
    assign full    = (count_r == CNT_W'(DEPTH));
    assign rd_vld  = rd_vld_r;
    assign rd_data = rd_data_r;

endmodule

// File: rtl/rf_bank_req_queue.sv
// Register-file bank request queue: splits one or two operand reads into
// per-bank FIFOs and issues at most one registered read per bank per cycle,
// giving way to a writeback on the same bank.
module rf_bank_req_queue
    import rf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    rf_bank_req_queue_if.slave bus
);

    logic [NUM_BANKS-1:0] na_s;
    logic [NUM_BANKS-1:0] nb_s;
    logic [NUM_BANKS-1:0] fit_s;
    logic [NUM_BANKS-1:0] stall_s;
    logic [NUM_BANKS-1:0] full_s;
    logic [NUM_BANKS-1:0] rd_vld_s;
    logic [1:0]           need_s    [NUM_BANKS];
    logic [CNT_W-1:0]     count_s   [NUM_BANKS];
    entry_t               rd_data_s [NUM_BANKS];
    logic                 req_ready_s;
    logic                 accept_s;
    entry_t               entry_a_s;
    entry_t               entry_b_s;

    assign entry_a_s = '{row: bus.rowid_a, ocid: bus.ocid, opsel: 1'b0};
    assign entry_b_s = '{row: bus.rowid_b, ocid: bus.ocid, opsel: 1'b1};

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign na_s[b]    = (bus.bankid_a == BANK_W'(b));
        assign nb_s[b]    = bus.req_2op && (bus.bankid_b == BANK_W'(b));
        assign need_s[b]  = 2'(na_s[b]) + 2'(nb_s[b]);
        assign fit_s[b]   = slots_fit(count_s[b], need_s[b]);
        assign stall_s[b] = bus.wb_valid && (bus.wb_bank == BANK_W'(b));

        bank_req_fifo u_fifo (
            .clk       (clk),
            .rst       (rst),
            .wr_en_a   (accept_s && na_s[b]),
            .wr_data_a (entry_a_s),
            .wr_en_b   (accept_s && nb_s[b]),
            .wr_data_b (entry_b_s),
            .stall     (stall_s[b]),
            .count     (count_s[b]),
            .full      (full_s[b]),
            .rd_vld    (rd_vld_s[b]),
            .rd_data   (rd_data_s[b])
        );

        assign bus.bk_rd_row[b*ROW_W +: ROW_W]    = rd_data_s[b].row;
        assign bus.bk_rd_ocid[b*OCID_W +: OCID_W] = rd_data_s[b].ocid;
        assign bus.bk_rd_opsel[b]                 = rd_data_s[b].opsel;
    end

    // Ready only from registered occupancy (no credit for same-cycle pops), held low in reset
    always_comb begin
        req_ready_s = 1'b0;
        if (rst) begin
            req_ready_s = &fit_s;
        end else begin
            req_ready_s = 1'b0;
        end
    end

    assign accept_s      = bus.req_valid && req_ready_s;
    assign bus.req_ready = req_ready_s;
    assign bus.bk_rd_vld = rd_vld_s;
    assign bus.bank_full = full_s;

endmodule

// File: tb/tb_rf_bank_req_queue.sv
// Self-checking bench for rf_bank_req_queue: a per-bank reference queue
// predicts which bank issues on each edge and with which entry.
module tb_rf_bank_req_queue;

    logic clk;
    logic rst;
    int   total_cnt;
    int   bad_cnt;

    // Expected entries per bank, packed {row[2:0], ocid[1:0], opsel}
    logic [5:0] sbq [4][$];

    rf_bank_req_queue_if bif ();

    rf_bank_req_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bif.req_valid = 1'b0;
        bif.req_2op   = 1'b0;
        bif.rowid_a   = 3'd0;
        bif.bankid_a  = 2'd0;
        bif.rowid_b   = 3'd0;
        bif.bankid_b  = 2'd0;
        bif.ocid      = 2'd0;
    endtask

    task automatic set_req(input logic two, input logic [2:0] ra, input logic [1:0] ba,
                           input logic [2:0] rb, input logic [1:0] bb, input logic [1:0] oc);
        bif.req_valid = 1'b1;
        bif.req_2op   = two;
        bif.rowid_a   = ra;
        bif.bankid_a  = ba;
        bif.rowid_b   = rb;
        bif.bankid_b  = bb;
        bif.ocid      = oc;
    endtask

    task automatic set_wb(input logic v, input logic [1:0] bk);
        bif.wb_valid = v;
        bif.wb_bank  = bk;
    endtask

    // One clock: check ready before the edge, advance model, check issue after it
    task automatic cycle();
        logic       exp_rdy;
        logic [3:0] pop_m;
        logic [3:0] full_m;
        logic [5:0] outv [4];
        int         need;
        @(negedge clk);
        exp_rdy = 1'b1;
        for (int b = 0; b < 4; b++) begin
            need = ((bif.bankid_a == 2'(b)) ? 1 : 0) +
                   ((bif.req_2op && (bif.bankid_b == 2'(b))) ? 1 : 0);
            if (sbq[b].size() + need > 4) exp_rdy = 1'b0;
            pop_m[b] = (sbq[b].size() > 0) && !(bif.wb_valid && (bif.wb_bank == 2'(b)));
            outv[b]  = 6'd0;
        end
        check_eq("req_ready", 32'(bif.req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        for (int b = 0; b < 4; b++) begin
            if (pop_m[b]) outv[b] = sbq[b].pop_front();
        end
        if (bif.req_valid && exp_rdy) begin
            sbq[bif.bankid_a].push_back({bif.rowid_a, bif.ocid, 1'b0});
            if (bif.req_2op) sbq[bif.bankid_b].push_back({bif.rowid_b, bif.ocid, 1'b1});
        end
        check_eq("bk_rd_vld", 32'(bif.bk_rd_vld), 32'(pop_m));
        for (int b = 0; b < 4; b++) begin
            if (pop_m[b]) begin
                check_eq($sformatf("row[%0d]", b),   32'(bif.bk_rd_row[b*3 +: 3]),  32'(outv[b][5:3]));
                check_eq($sformatf("ocid[%0d]", b),  32'(bif.bk_rd_ocid[b*2 +: 2]), 32'(outv[b][2:1]));
                check_eq($sformatf("opsel[%0d]", b), 32'(bif.bk_rd_opsel[b]),       32'(outv[b][0]));
            end
            full_m[b] = (sbq[b].size() == 4);
        end
        check_eq("bank_full", 32'(bif.bank_full), 32'(full_m));
    endtask

    task automatic run_idle(input int n);
        idle();
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst       = 1'b0;
        idle();
        set_wb(1'b0, 2'd0);

        // Reset state
        #12;
        check_eq("rst_vld",   32'(bif.bk_rd_vld),   32'd0);
        check_eq("rst_ready", 32'(bif.req_ready),   32'd0);
        check_eq("rst_full",  32'(bif.bank_full),   32'd0);
        check_eq("rst_row",   32'(bif.bk_rd_row),   32'd0);
        check_eq("rst_ocid",  32'(bif.bk_rd_ocid),  32'd0);
        check_eq("rst_opsel", 32'(bif.bk_rd_opsel), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_idle(2);

        // Single op to bank2: issue appears one edge after the push edge
        set_req(1'b0, 3'd5, 2'd2, 3'd0, 2'd0, 2'd1);
        cycle();
        run_idle(3);

        // Same-bank pair: row3 (a) then row6 (b) on consecutive cycles
        set_req(1'b1, 3'd3, 2'd1, 3'd6, 2'd1, 2'd2);
        cycle();
        run_idle(4);

        // Fill bank0 behind a writeback stall, then backpressure
        set_wb(1'b1, 2'd0);
        for (int i = 0; i < 4; i++) begin
            set_req(1'b0, 3'(i + 1), 2'd0, 3'd0, 2'd0, 2'(i));
            cycle();
        end
        set_req(1'b0, 3'd7, 2'd0, 3'd0, 2'd0, 2'd3);
        cycle();
        set_req(1'b1, 3'd2, 2'd3, 3'd0, 2'd0, 2'd0);
        cycle();
        set_req(1'b1, 3'd4, 2'd3, 3'd5, 2'd3, 2'd2);
        cycle();
        idle();
        cycle();
        set_wb(1'b0, 2'd0);
        run_idle(6);

        // Near full: bank0 at 3 refuses a two-slot request, takes a single
        set_wb(1'b1, 2'd0);
        for (int i = 0; i < 3; i++) begin
            set_req(1'b0, 3'(i + 4), 2'd0, 3'd0, 2'd0, 2'd1);
            cycle();
        end
        set_req(1'b1, 3'd1, 2'd0, 3'd2, 2'd0, 2'd2);
        cycle();
        cycle();
        set_req(1'b0, 3'd6, 2'd0, 3'd0, 2'd0, 2'd3);
        cycle();
        set_wb(1'b0, 2'd0);
        run_idle(6);

        // Wrap-around: ten back-to-back singles to bank2
        for (int i = 0; i < 10; i++) begin
            set_req(1'b0, 3'(i % 8), 2'd2, 3'd0, 2'd0, 2'(i % 4));
            cycle();
        end
        run_idle(4);

        // Mixed traffic with random writeback stalls
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                set_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                        3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            end else begin
                idle();
            end
            set_wb(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            cycle();
        end
        set_wb(1'b0, 2'd0);
        run_idle(8);

        // Reset mid-flight: three queued on bank1, one just issued
        set_wb(1'b1, 2'd1);
        for (int i = 0; i < 3; i++) begin
            set_req(1'b0, 3'(i + 2), 2'd1, 3'd0, 2'd0, 2'd1);
            cycle();
        end
        idle();
        set_wb(1'b0, 2'd0);
        cycle();
        #1;
        rst = 1'b0;
        #1;
        check_eq("midrst_vld",   32'(bif.bk_rd_vld), 32'd0);
        check_eq("midrst_ready", 32'(bif.req_ready), 32'd0);
        check_eq("midrst_full",  32'(bif.bank_full), 32'd0);
        for (int b = 0; b < 4; b++) sbq[b].delete();
        rst = 1'b1;
        run_idle(5);
        set_req(1'b0, 3'd7, 2'd1, 3'd0, 2'd0, 2'd3);
        cycle();
        run_idle(3);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
